// File: rtl/video_pkg.sv
// Shared constants and state type for the planar pixel datapath.
package video_pkg;

  localparam int unsigned PLANES_DEFAULT = 4;
  localparam int unsigned GROUP_WIDTH    = 8;
  localparam int unsigned IDX_W          = $clog2(GROUP_WIDTH) + 1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/plane_shift_in.sv
// Single-plane serial-in shift register with direction select.
// dir=0 shifts left inserting at LSB (first bit ends at MSB);
// dir=1 shifts right inserting at MSB (first bit ends at LSB).
module plane_shift_in #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift,
  input  logic             dir,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] base;

  // Clear and shift may coincide: the new bit is inserted into an empty register.
  always_comb begin
    base = clear ? '0 : q;
  end

  // Shift register update.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (shift) begin
      q <= dir ? {d, base[WIDTH-1:1]} : {base[WIDTH-2:0], d};
    end else if (clear) begin
      q <= '0;
    end
  end

endmodule

// File: rtl/planar_deserializer.sv
// Collects one bit per plane per pixel and repacks WIDTH-pixel groups into
// per-plane bytes, delivered through a valid/ready handshake with a sticky
// overrun flag.
module planar_deserializer
  import video_pkg::*;
#(
  parameter int unsigned PLANES = PLANES_DEFAULT,
  parameter int unsigned WIDTH  = GROUP_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    start,
  input  logic                    flip,
  input  logic [PLANES-1:0]       bit_in,
  output logic [PLANES*WIDTH-1:0] byte_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    overrun
);

  localparam int unsigned    IW   = $clog2(WIDTH) + 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  state_t                  state;
  logic [IW-1:0]           idx;
  logic                    flip_q;
  logic                    done_q;
  logic                    begin_s;
  logic                    step_s;
  logic                    complete;
  logic                    shift_en;
  logic                    dir;
  logic [PLANES*WIDTH-1:0] group;

  // Sample qualification: start always wins and restarts at index 0.
  always_comb begin
    begin_s  = ce & start;
    step_s   = ce & ~start & (state == COLLECT);
    complete = step_s & (idx == LAST);
    shift_en = begin_s | step_s;
    dir      = begin_s ? flip : flip_q;
  end

  for (genvar p = 0; p < PLANES; p++) begin : g_plane
    plane_shift_in #(.WIDTH(WIDTH)) u_shift (
      .clock (clock),
      .reset (reset),
      .clear (begin_s),
      .shift (shift_en),
      .dir   (dir),
      .d     (bit_in[p]),
      .q     (group[p*WIDTH +: WIDTH])
    );
  end

  // Collection FSM and index counter; done_q marks a fully shifted group.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      flip_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= complete;
      if (begin_s) begin
        state  <= COLLECT;
        idx    <= IW'(1);
        flip_q <= flip;
      end else if (complete) begin
        state <= IDLE;
        idx   <= '0;
      end else if (step_s) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Output register, handshake and sticky overrun.
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (done_q) begin
      if (out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else begin
        byte_out  <= group;
        out_valid <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_comb begin
    busy = (state == COLLECT);
  end

endmodule

// File: tb/tb_planar_deserializer.sv
// Directed bench for planar_deserializer (PLANES=4, WIDTH=8).
// Streams are written MSB-first: stream bit 7-k of plane p is sample k.
module tb_planar_deserializer;

  logic        clock;
  logic        reset;
  logic        ce;
  logic        start;
  logic        flip;
  logic [3:0]  bit_in;
  logic [31:0] byte_out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        overrun;

  int unsigned errors;
  int unsigned checks;

  planar_deserializer #(.PLANES(4), .WIDTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .ce        (ce),
    .start     (start),
    .flip      (flip),
    .bit_in    (bit_in),
    .byte_out  (byte_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] s, input logic f, input int unsigned gap,
                      input int unsigned nbits, input logic chk_busy);
    for (int k = 0; k < int'(nbits); k++) begin
      ce    = 1'b1;
      start = (k == 0);
      flip  = f;
      for (int p = 0; p < 4; p++) bit_in[p] = s[p*8 + 7 - k];
      step();
      ce    = 1'b0;
      start = 1'b0;
      if (chk_busy) chk($sformatf("busy_s%0d", k), {31'd0, busy}, (k == 7) ? 32'd0 : 32'd1);
      if (k < int'(nbits) - 1) begin
        for (int g = 0; g < int'(gap); g++) begin
          step();
          if (chk_busy) chk("busy_gap", {31'd0, busy}, 32'd1);
        end
      end
    end
    ce     = 1'b0;
    start  = 1'b0;
    bit_in = '0;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    ce        = 1'b0;
    start     = 1'b0;
    flip      = 1'b0;
    bit_in    = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_byte", byte_out, 32'h0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    step();

    // Samples without start are ignored in IDLE.
    ce = 1'b1; bit_in = 4'hF; step(); step(); ce = 1'b0; bit_in = '0;
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Normal packing 1,0,1,0,0,1,0,1 -> 0xA5, one-clock valid.
    send(32'h000000A5, 1'b0, 0, 8, 1'b0);
    chk("norm_valid_early", {31'd0, out_valid}, 32'd0);
    step();
    chk("norm_valid", {31'd0, out_valid}, 32'd1);
    chk("norm_byte", byte_out, 32'h000000A5);
    step();
    chk("norm_valid_drop", {31'd0, out_valid}, 32'd0);

    // Flip packing of a palindrome stream.
    send(32'h000000A5, 1'b1, 0, 8, 1'b0);
    step();
    chk("flip_a5", byte_out, 32'h000000A5);
    step();

    // Stream 1,1,0,0,0,0,0,0 flipped vs normal.
    send(32'h000000C0, 1'b1, 0, 8, 1'b0);
    step();
    chk("flip_03", byte_out, 32'h00000003);
    step();
    send(32'h000000C0, 1'b0, 0, 8, 1'b0);
    step();
    chk("norm_c0", byte_out, 32'h000000C0);
    step();

    // Four planes, ce every third clock, busy tracked throughout.
    send(32'h78563412, 1'b0, 2, 8, 1'b1);
    step();
    chk("mp_valid", {31'd0, out_valid}, 32'd1);
    chk("mp_byte", byte_out, 32'h78563412);
    step();

    // Early restart: partial group aborted silently.
    send(32'h000000FF, 1'b0, 0, 3, 1'b0);
    chk("er_busy", {31'd0, busy}, 32'd1);
    send(32'h0000005A, 1'b0, 0, 8, 1'b0);
    chk("er_valid_early", {31'd0, out_valid}, 32'd0);
    step();
    chk("er_valid", {31'd0, out_valid}, 32'd1);
    chk("er_byte", byte_out, 32'h0000005A);
    chk("er_overrun", {31'd0, overrun}, 32'd0);
    step();
    chk("er_single", {31'd0, out_valid}, 32'd0);

    // Backpressure: second back-to-back group is dropped.
    out_ready = 1'b0;
    send(32'h00000011, 1'b0, 0, 8, 1'b0);
    send(32'h00000022, 1'b0, 0, 8, 1'b0);
    chk("bp_valid1", {31'd0, out_valid}, 32'd1);
    chk("bp_byte1", byte_out, 32'h00000011);
    chk("bp_ovr_pre", {31'd0, overrun}, 32'd0);
    step();
    chk("bp_byte2", byte_out, 32'h00000011);
    chk("bp_valid2", {31'd0, out_valid}, 32'd1);
    chk("bp_overrun", {31'd0, overrun}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_drop", {31'd0, out_valid}, 32'd0);
    chk("bp_ovr_sticky", {31'd0, overrun}, 32'd1);

    // Reset mid-group.
    send(32'h000000FF, 1'b0, 0, 5, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_byte", byte_out, 32'h0);
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_overrun", {31'd0, overrun}, 32'd0);
    send(32'h000000C3, 1'b0, 0, 8, 1'b0);
    step();
    chk("mr_valid2", {31'd0, out_valid}, 32'd1);
    chk("mr_byte2", byte_out, 32'h000000C3);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/planar_deserializer.md
Name: planar_deserializer

Overview:
- Serial-to-parallel counterpart of the tile/sprite pixel shifter: collects one bit per plane per pixel and reassembles 8-pixel groups into per-plane bytes.
- Used in video capture and line-buffer write-back paths, where planar pixel streams must be repacked into ROM/RAM byte format.
- Supports normal (first bit to MSB) and reversed (first bit to LSB) packing for h-flip.
- Completed groups go through a valid/ready handshake with a sticky overrun flag.

Parameters:
- PLANES, 4, number of bit planes (serial inputs / output bytes).
- WIDTH, 8, bits per group (output byte width).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  pixel clock enable; input is sampled only when ce=1.
- start  in  1  qualified by ce; marks the current sample as bit 0 of a new group.
- flip  in  1  sampled together with start; 0 = first bit to MSB, 1 = first bit to LSB.
- bit_in  in  PLANES  one serial bit per plane (bit_in[0] = plane 1).
- byte_out  out  PLANES*WIDTH  assembled bytes; plane p in [p*WIDTH +: WIDTH].
- out_valid  out  1  byte_out holds an unconsumed group.
- out_ready  in  1  consumer accepts the group when out_valid & out_ready.
- busy  out  1  group collection in progress (state COLLECT).
- overrun  out  1  sticky: a completed group was dropped.

Behaviour:
- Reset values: byte_out=0, out_valid=0, busy=0, overrun=0; index counter=0; state IDLE. Reset mid-group discards the partial group and any pending output.
- States:
  - IDLE: samples with ce=1 and start=0 are ignored.
  - COLLECT: entered on ce&start from any state.
- Bit placement: on ce&start, latch flip into flip_q, clear the shift registers, store bit_in as bit index 0, set index=1.
  - In COLLECT, each ce=1 sample (start=0) stores bit index k.
  - flip_q=0: bit k lands at position WIDTH-1-k. flip_q=1: bit k lands at position k.
  - Implementation: shift left inserting at LSB, or shift right inserting at MSB.
- Completion: the sample with index WIDTH-1 completes the group.
  - On the next clock edge, the group transfers to byte_out and out_valid=1.
  - Latency from the last sample edge to out_valid high is 1 clock.
  - State returns to IDLE unless start is asserted at that sample.
- Back-to-back groups: start on the ce cycle immediately after completion begins a new group with no gap.
- Early start: start while in COLLECT with index < WIDTH aborts the partial group silently (no overrun) and restarts at index 0 with the current bit.
- ce=0 cycles hold all collection state; out_valid and the handshake are unaffected by ce.
- Handshake:
  - out_valid stays high until a clock with out_ready=1; it then drops on the next edge unless a new group completes on that same edge, in which case it stays high with the new data.
  - byte_out is stable while out_valid=1 and no accept has occurred.
- Overrun: if a group completes while out_valid=1 and out_ready=0, the new group is dropped, byte_out is unchanged, and overrun is set. overrun clears only on reset.
- Arithmetic: index counter is $clog2(WIDTH)+1 bits wide, with no wrap; completion is detected at index==WIDTH-1 on a sampled bit.

Decomposition:
- Shared package video_pkg: constants PLANES_DEFAULT=4 and GROUP_WIDTH=8; localparam for index width; typedef for the state enum (IDLE, COLLECT).
- Sub-module plane_shift_in (one per plane, generate loop):
  - Inputs: clock, reset, clear, shift, dir, d. Output: q[WIDTH-1:0].
- Top level contains the counter, the FSM, the output register, the handshake and overrun logic.

Test Plan:
- Normal packing:
  - Stimulus: out_ready=1, flip=0, start on the first of 8 ce pulses; plane1 serial 1,0,1,0,0,1,0,1.
  - Response: byte_out plane1=0xA5, out_valid=1 for exactly 1 clock, one cycle after the 8th sample.
- Flip packing:
  - Stimulus: same serial stream with flip=1.
  - Response: plane1=0xA5 bit-reversed=0xA5. Repeat with stream 1,1,0,0,0,0,0,0 → 0x03 (flip) vs 0xC0 (normal).
- ce gaps and multi-plane:
  - Stimulus: 4 planes carrying 0x12, 0x34, 0x56, 0x78 with ce=1 every third clock.
  - Response: byte_out={0x78,0x56,0x34,0x12}; busy high from the first sample until completion.
- Early restart:
  - Stimulus: start, 3 bits, start again, then 8 bits encoding 0x5A.
  - Response: single out_valid with 0x5A; overrun=0.
- Backpressure/overrun:
  - Stimulus: out_ready=0; two back-to-back groups 0x11 then 0x22.
  - Response: byte_out stays 0x11, overrun=1 after the second completion. Raise out_ready: out_valid drops the next clock; overrun stays 1.
- Reset mid-group:
  - Stimulus: 5 bits collected, then reset for 1 clock, then a full group 0xC3.
  - Response: all outputs 0 after reset, busy=0; the next group yields exactly 0xC3.
